// File: rtl/square_colour_ctrl.sv
// Colour controller for the OLED squares: debounced buttons, a mode FSM driven by SW[15:13],
// a cursor selecting one square and per-square colour registers packed onto colour_bus.
module square_colour_ctrl #(
  parameter int NUM_SQUARES     = 4,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int AUTO_PERIOD     = 100000000,
  parameter int INIT_COLOUR     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     btnL,
  input  logic                     btnR,
  input  logic                     btnC,
  input  logic [15:0]              SW,
  output logic [3*NUM_SQUARES-1:0] colour_bus,
  output logic [2:0]               cursor,
  output logic                     step_pulse
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int TMR_W  = $clog2(AUTO_PERIOD);

  localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DCNT_ONE    = DCNT_W'(1);
  localparam logic [TMR_W-1:0]  TMR_LAST    = TMR_W'(AUTO_PERIOD - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE     = TMR_W'(1);
  localparam logic [2:0]        CUR_LAST    = 3'(NUM_SQUARES - 1);
  localparam logic [2:0]        COLOUR_INIT = 3'(INIT_COLOUR);

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_C = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_AUTO   = 2'd2
  } state_t;

  // Red -> Blue -> Yellow -> Green -> White -> Red
  function automatic logic [2:0] step_colour(input logic [2:0] c);
    return (c == 3'd4) ? 3'd0 : c + 3'd1;
  endfunction

  state_t            state_reg, state_next;
  logic              manual_en, auto_en, auto_entry;
  logic [TMR_W-1:0]  timer_reg, timer_next;
  logic              auto_tick;
  logic [2:0]        btn_raw, press;
  logic              press_l, press_r, press_c;
  logic [2:0]        cursor_reg, cursor_next;
  logic [NUM_SQUARES-1:0] sq_changed;
  logic              step_pulse_reg;
  logic              sw_unused;

  assign sw_unused = ^SW[12:0];

  // ---------------------------------------------------------------- buttons
  assign btn_raw = {btnC, btnR, btnL};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic              s1_reg, s2_reg, deb_reg, deb_d_reg;
    logic [DCNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_reg    <= 1'b0;
        s2_reg    <= 1'b0;
        deb_reg   <= 1'b0;
        deb_d_reg <= 1'b0;
        cnt_reg   <= '0;
      end else begin
        s1_reg    <= btn_raw[gi];
        s2_reg    <= s1_reg;
        deb_d_reg <= deb_reg;
        // Any agreement restarts the run, so bounces shorter than the window are ignored.
        if (s2_reg == deb_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DCNT_LAST) begin
          deb_reg <= ~deb_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + DCNT_ONE;
        end
      end
    end

    assign press[gi] = deb_reg & ~deb_d_reg;
  end

  // ---------------------------------------------------------------- mode FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    case (SW[15:13])
      3'b001:  state_next = ST_MANUAL;
      3'b010:  state_next = ST_AUTO;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    manual_en  = (state_reg == ST_MANUAL);
    auto_en    = (state_reg == ST_AUTO);
    auto_entry = (state_next == ST_AUTO) && (state_reg != ST_AUTO);
  end

  // ---------------------------------------------------------------- auto timer
  always_comb begin
    auto_tick  = auto_en && (timer_reg == TMR_LAST);
    timer_next = timer_reg;
    if (auto_entry || auto_tick) begin
      timer_next = '0;
    end else if (auto_en) begin
      timer_next = timer_reg + TMR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_next;
    end
  end

  // ---------------------------------------------------------------- cursor
  always_comb begin
    press_l     = manual_en & press[BTN_L];
    press_r     = manual_en & press[BTN_R];
    press_c     = manual_en & press[BTN_C];
    cursor_next = cursor_reg;
    if (press_l && !press_r) begin
      cursor_next = (cursor_reg == 3'd0) ? CUR_LAST : cursor_reg - 3'd1;
    end else if (press_r && !press_l) begin
      cursor_next = (cursor_reg == CUR_LAST) ? 3'd0 : cursor_reg + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cursor_reg <= 3'd0;
    end else begin
      cursor_reg <= cursor_next;
    end
  end

  // ---------------------------------------------------------------- squares
  for (genvar gi = 0; gi < NUM_SQUARES; gi++) begin : g_sq
    logic [2:0] col_reg, col_next;

    // The manual step compares against cursor_reg, i.e. the pre-move cursor.
    always_comb begin
      col_next = col_reg;
      if (auto_tick || (press_c && (cursor_reg == 3'(gi)))) begin
        col_next = step_colour(col_reg);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        col_reg <= COLOUR_INIT;
      end else begin
        col_reg <= col_next;
      end
    end

    assign colour_bus[3*gi +: 3] = col_reg;
    assign sq_changed[gi]        = (col_next != col_reg);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_pulse_reg <= 1'b0;
    end else begin
      step_pulse_reg <= |sq_changed;
    end
  end

  assign cursor     = cursor_reg;
  assign step_pulse = step_pulse_reg;

endmodule

// File: doc/square_colour_ctrl.md
# square_colour_ctrl

Controller that owns the colours of several on-screen squares and drives them from the board's push-buttons and mode switches. It synchronises and debounces the three raw buttons. It keeps a cursor selecting one square, advances that square's colour in manual mode, and advances all squares on a fixed period in auto mode. The packed colour bus feeds the OLED square renderer directly.

## Interface
- NUM_SQUARES, 4, number of squares controlled; legal range 2..8.
- DEBOUNCE_CYCLES, 200000, consecutive stable synchronised cycles needed to accept a button level change; legal minimum 2.
- AUTO_PERIOD, 100000000, clock cycles between auto-mode colour steps; legal minimum 2.
- INIT_COLOUR, 0, reset colour of every square; legal range 0..4.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- btnL  in  1  raw, asynchronous left button; moves the cursor down.
- btnR  in  1  raw, asynchronous right button; moves the cursor up.
- btnC  in  1  raw, asynchronous centre button; steps the colour.
- SW  in  16  slide switches; only SW[15:13] are decoded.
- colour_bus  out  3*NUM_SQUARES  colour of square i in bits [3i+2:3i].
- cursor  out  3  index of the selected square, 0..NUM_SQUARES-1.
- step_pulse  out  1  one-cycle strobe in the cycle after any colour register changes.

## Operation
- Colour encoding: 0 Red, 1 Blue, 2 Yellow, 3Green, 4 White. Step rule: 4 -> 0, otherwise +1. Values 5..7 never appear.
- Button front end, one instance per button:
  - 2-flop synchroniser (s1, s2), then a debounced level deb, reset to 0.
  - A counter increments on each edge where s2 != deb. It clears on any edge where s2 == deb.
  - When the counter has seen DEBOUNCE_CYCLES consecutive differing edges, deb flips and the counter clears.
  - Press pulse = deb & ~deb_d, one cycle wide. deb_d is deb delayed by one register.
- Mode FSM states: IDLE, MANUAL, AUTO.
  - The state is re-evaluated every cycle from SW[15:13]: 3'b001 -> MANUAL, 3'b010 -> AUTO, any other value -> IDLE.
  - Reset state is IDLE.
- IDLE: colours and cursor hold. Press pulses are discarded.
- MANUAL:
  - L pulse: cursor = (cursor==0) ? NUM_SQUARES-1 : cursor-1.
  - R pulse: cursor = (cursor==NUM_SQUARES-1) ? 0 : cursor+1.
  - C pulse: the square at the current cursor steps.
  - L and R pulses in the same cycle cancel; the cursor is unchanged.
  - C together with L or R in the same cycle: the colour step uses the pre-move cursor, and the cursor moves in the same edge.
- AUTO:
  - A timer counts 0..AUTO_PERIOD-1. At terminal count all squares step in the same edge and the timer wraps to 0.
  - The timer is forced to 0 on the edge that enters AUTO.
  - The cursor holds. All press pulses are discarded.
- Leaving AUTO: colours hold. The timer value is irrelevant afterwards because it is re-zeroed on the next entry.
- step_pulse is registered. It goes high in the cycle after any edge that changed one or more colour registers.

## Timing
- Reset values, applied at any edge with rst_n=0 regardless of state:
  - colour_bus: all fields INIT_COLOUR.
  - cursor 0, step_pulse 0, state IDLE.
  - s1, s2, deb, deb_d, debounce counters and auto timer all 0.
- Reset mid-operation: all in-flight debounce counts and partial auto periods are lost. A button held through reset produces exactly one press, DEBOUNCE_CYCLES+2 edges after release of reset.
- Button latency: let edge N be the first edge at which s1 samples the raw input high, with the input held stable.
  - s2 = 1 after edge N+1.
  - deb = 1 after edge N+1+DEBOUNCE_CYCLES.
  - The colour or cursor register updates at edge N+2+DEBOUNCE_CYCLES.
  - step_pulse is high during the cycle after that edge.
- Bounce: any return of s2 to deb before the count completes restarts the count. Release is debounced identically and produces no pulse.
- Mode-change latency: the SW value sampled at edge E governs the action taken at edge E+1. There is no synchroniser on SW.
- Auto: with entry at edge E, steps occur at edges E+AUTO_PERIOD, E+2*AUTO_PERIOD, and so on.

## Test plan
Parameters for all tests: NUM_SQUARES=4, DEBOUNCE_CYCLES=4, AUTO_PERIOD=8, INIT_COLOUR=0.

1. Reset, then SW[15:13]=001. Give six clean btnC presses, each held 10 cycles with 10-cycle gaps -> square 0 goes 1,2,3,4,0,1. Other fields stay 0. There are six step_pulse strobes, each at edge N+6 timing.
2. MANUAL: btnL once from cursor 0 -> cursor 3. btnR twice -> cursor 1. Then btnC -> colour_bus = 12'h008, i.e. square 1 = Blue.
3. Bounce: btnC toggles high/low every 2 cycles for 20 cycles, then holds high -> exactly one step. It lands 6 edges after the final stable rise.
4. Simultaneous events: btnL and btnR rise on the same edge -> cursor unchanged. With cursor 2, btnC and btnR together -> square 2 steps and cursor becomes 3.
5. AUTO: switch SW[15:13] to 010 at edge E -> all four squares step at E+8 and E+16. btnC presses during AUTO change nothing. Switching to 000 at E+20 -> colours hold at 2 and no further step_pulse.
6. Reset mid-run: assert rst_n=0 for 1 cycle while in AUTO with colours at 3 -> next cycle colour_bus=0, cursor=0, step_pulse=0, state IDLE. btnC held through reset -> exactly one press once back in MANUAL.
